fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier. Successor to the combinational single-precision FPU multiplier.
- Adds configurable exponent/fraction widths, a 3-stage pipeline with valid/ready handshake and full backpressure, a pass-through tag, and complete special-value and flag handling.
- Sits in the FPU execute path between operand dispatch and the result/writeback mux.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; word width W = 1+EXP_W+FRAC_W.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operation this cycle.
- fp_x  in  W  operand X.
- fp_y  in  W  operand Y.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- fp_z  out  W  product.
- out_tag  out  TAG_W  tag of this result.
- ovrf  out  1  overflow.
- udrf  out  1  underflow (flushed).
- nv  out  1  invalid operation.

Behaviour:
- Reset:
  - rst is sampled on clk; all stage valid bits are cleared.
  - fp_z, out_tag, ovrf, udrf, nv reset to 0; out_valid = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial results appear.
- Pipeline:
  - S1: classify operands, form sign, compute the biased exponent sum eX+eY-BIAS, and form the full (2*FRAC_W+2)-bit mantissa product.
  - S2: normalise. If the product MSB is set, exp += 1; otherwise shift left by 1. Keep FRAC_W+1 bits plus guard and round bits; sticky = OR of the remaining bits.
  - S3: round per r_mode, handle the mantissa carry-out (exp += 1, mantissa = 1.0), detect overflow/underflow, and pack.
- Latency and throughput:
  - Latency is 3 cycles from an accepted input to out_valid, with out_ready held high.
  - Throughput is 1 operation per cycle.
- Handshake:
  - adv = !out_valid || out_ready. All stages shift together when adv = 1 and hold otherwise.
  - in_ready = adv.
  - An input is accepted on in_valid && in_ready.
  - out_valid, fp_z, out_tag and the flags are stable while out_valid && !out_ready.
  - Bubbles are not collapsed.
  - Ordering is strictly FIFO.
- Operand classes:
  - exp == 0 is zero/subnormal; subnormal inputs are treated as zero.
  - exp all-ones with frac == 0 is Inf; exp all-ones with frac != 0 is NaN.
- Rounding:
  - RNE: round up if G && (R || S || LSB).
  - RTZ: truncate.
  - RDN: round up magnitude if sign && (G || R || S).
  - RUP: round up magnitude if !sign && (G || R || S).
  - RMM: round up if G.
- Special cases (in priority order):
  - Any NaN input, or Inf*zero: output canonical qNaN {0, all-ones exp, MSB frac = 1, rest 0}, nv = 1.
  - Inf*non-zero: output signed Inf.
  - Zero/subnormal * finite: output signed zero.
- Overflow (final biased exp >= 2^EXP_W-1): ovrf = 1.
  - Result is signed Inf for RNE, RMM, RDN negative, and RUP positive.
  - Otherwise the result is the signed max finite value (exp all-ones-1, frac all-ones).
- Underflow (final biased exp <= 0): result is signed zero, udrf = 1; no subnormal output.
- Flags are per-result and valid only with out_valid. They are never set for special-value outputs other than nv.
- The sign of zero and Inf results is always sign(X) XOR sign(Y).

Optional Feature:
- Macro FP_MUL_ASSERT_EN.
- Defined: embedded immediate and concurrent assertions are compiled in:
  - S2 normalised mantissa MSB == 1 for non-special operations.
  - Sticky bit equals OR of the discarded product bits.
  - Output sign equals the XOR of the input signs.
  - Payload stable under stall.
  - A rounding carry implies the mantissa was all-ones.
  - in_ready == (!out_valid || out_ready).
- Not defined: no assertion code is compiled; RTL behaviour is identical.

Decomposition:
- Package fp_mul_pkg holds:
  - typedef rmode_e (RNE, RTZ, RDN, RUP, RMM);
  - struct fp_class_t {zero, inf, nan, sign};
  - functions bias(EXP_W) and qnan(EXP_W, FRAC_W).
- One sub-module, fp_round, holds the combinational S3 rounding of mantissa + G/R/S + sign + r_mode, producing the rounded mantissa and a carry.

Test Plan (FP32 defaults):
- 0x40400000 * 0x40000000, RNE, tag 5 → 0x40C00000, out_tag 5, out_valid 3 cycles after accept, all flags 0.
- 0x3F800001 * 0x3F800001 → RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003, RDN 0x3F800002. Negating X with RDN gives 0xBF800003.
- 0x7F000000 * 0x7F000000 → RNE 0x7F800000 ovrf=1; RTZ 0x7F7FFFFF ovrf=1.
- 0x00800000 * 0x00800000 → 0x00000000 udrf=1; 0x80000001 * 0x3F800000 → 0x80000000 (subnormal flushed), no flags.
- 0x7F800000 * 0x00000000 → 0x7FC00000 nv=1; 0xFF800000 * 0x40000000 → 0xFF800000.
- Issue 6 back-to-back ops with out_ready=0 for 8 cycles → in_ready drops after 3 accepted, output held stable; release out_ready → 6 results in order with correct tags. Asserting rst mid-burst → out_valid=0 next cycle and no stale results.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined FP multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic sign;
    } fp_class_t;

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN, returned wide; callers keep the low 1+ew+fw bits.
    function automatic logic [127:0] qnan(input int ew, input int fw);
        logic [127:0] z;
        z = ((128'(1) << ew) - 128'(1)) << fw;
        z = z | (128'(1) << (fw - 1));
        return z;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_round.sv
// Combinational rounding of the normalised mantissa using guard/round/sticky.
module fp_round
    import fp_mul_pkg::*;
#(
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W:0] mant_i,
    input  logic            g_i,
    input  logic            r_i,
    input  logic            s_i,
    input  logic            sign_i,
    input  rmode_e          rm_i,
    output logic [FRAC_W:0] mant_o,
    output logic            carry_o
);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    always_comb begin
        inc = 1'b0;
        case (rm_i)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign_i & (g_i | r_i | s_i);
            RUP:     inc = ~sign_i & (g_i | r_i | s_i);
            RMM:     inc = g_i;
            default: inc = g_i & (r_i | s_i | mant_i[0]);
        endcase
        sum     = {1'b0, mant_i} + (FRAC_W + 2)'(inc);
        carry_o = sum[FRAC_W+1];
        // A carry out means the mantissa wrapped to 10.00..0; renormalise to 1.0.
        mant_o  = carry_o ? {1'b1, {FRAC_W{1'b0}}} : sum[FRAC_W:0];
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-754 multiplier with valid/ready backpressure and tag pass-through.
// Define FP_MUL_ASSERT_EN to compile in the embedded assertions.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    parameter  int TAG_W  = 4,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     fp_x,
    input  logic [W-1:0]     fp_y,
    input  logic [2:0]       r_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     fp_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovrf,
    output logic             udrf,
    output logic             nv
);

    localparam int STAGES = 3;
    localparam int PW     = 2 * FRAC_W + 2;
    localparam int EW     = EXP_W + 2;
    localparam int BIAS   = bias(EXP_W);
    localparam int MAX_E  = (1 << EXP_W) - 1;
    localparam logic [127:0] QNAN_WIDE = qnan(EXP_W, FRAC_W);
    localparam logic [W-1:0] QNAN      = QNAN_WIDE[W-1:0];

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             inf;
        logic             zero;
        logic [EW-1:0]    exp;
        logic [PW-1:0]    prod;
        rmode_e           rm;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             inf;
        logic             zero;
        logic [EW-1:0]    exp;
        logic [FRAC_W:0]  mant;
        logic             g;
        logic             r;
        logic             s;
        rmode_e           rm;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [W-1:0]     z;
        logic [TAG_W-1:0] tag;
        logic             ovrf;
        logic             udrf;
        logic             nv;
    } out_t;

    logic [STAGES:1] vld_pipe_q;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    out_t            out_d, out_q;
    logic            adv;

    logic [EXP_W-1:0]  ex, ey;
    logic [FRAC_W-1:0] fx, fy;
    fp_class_t         cx, cy;
    logic [PW-1:0]     norm;
    logic [FRAC_W:0]   rnd_mant;
    logic              rnd_carry;
    logic [EW-1:0]     e_fin;
    logic              ofl, ufl, inf_sel;
    logic              unused_hidden;

    assign adv       = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[STAGES];
    assign fp_z      = out_q.z;
    assign out_tag   = out_q.tag;
    assign ovrf      = out_q.ovrf;
    assign udrf      = out_q.udrf;
    assign nv        = out_q.nv;

    assign ex = fp_x[W-2:FRAC_W];
    assign ey = fp_y[W-2:FRAC_W];
    assign fx = fp_x[FRAC_W-1:0];
    assign fy = fp_y[FRAC_W-1:0];

    // S1: classify, sign, biased exponent sum, full mantissa product.
    always_comb begin
        cx.zero = (ex == '0);
        cx.inf  = (&ex) && (fx == '0);
        cx.nan  = (&ex) && (fx != '0);
        cx.sign = fp_x[W-1];
        cy.zero = (ey == '0);
        cy.inf  = (&ey) && (fy == '0);
        cy.nan  = (&ey) && (fy != '0);
        cy.sign = fp_y[W-1];

        s1_d      = '0;
        s1_d.sign = cx.sign ^ cy.sign;
        s1_d.nan  = cx.nan | cy.nan | (cx.inf & cy.zero) | (cy.inf & cx.zero);
        s1_d.inf  = cx.inf | cy.inf;
        s1_d.zero = cx.zero | cy.zero;
        s1_d.exp  = EW'(ex) + EW'(ey) - EW'(BIAS);
        s1_d.prod = PW'({1'b1, fx}) * PW'({1'b1, fy});
        s1_d.rm   = (r_mode > 3'd4) ? RNE : rmode_e'(r_mode);
        s1_d.tag  = in_tag;
    end

    // S2: normalise the [1,4) product to 1.x and split off G/R/S.
    always_comb begin
        norm      = s1_q.prod[PW-1] ? s1_q.prod : {s1_q.prod[PW-2:0], 1'b0};
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
        s2_d.exp  = s1_q.exp + EW'(s1_q.prod[PW-1]);
        s2_d.mant = norm[PW-1:FRAC_W+1];
        s2_d.g    = norm[FRAC_W];
        s2_d.r    = norm[FRAC_W-1];
        s2_d.s    = |norm[FRAC_W-2:0];
        s2_d.rm   = s1_q.rm;
        s2_d.tag  = s1_q.tag;
    end

    fp_round #(.FRAC_W(FRAC_W)) u_round (
        .mant_i  (s2_q.mant),
        .g_i     (s2_q.g),
        .r_i     (s2_q.r),
        .s_i     (s2_q.s),
        .sign_i  (s2_q.sign),
        .rm_i    (s2_q.rm),
        .mant_o  (rnd_mant),
        .carry_o (rnd_carry)
    );

    assign unused_hidden = rnd_mant[FRAC_W];

    // S3: exponent fix-up, range checks, special-value priority, pack.
    always_comb begin
        e_fin = s2_q.exp + EW'(rnd_carry);
        ofl   = $signed(e_fin) >= $signed(EW'(MAX_E));
        ufl   = $signed(e_fin) <= $signed(EW'(0));
        case (s2_q.rm)
            RTZ:     inf_sel = 1'b0;
            RDN:     inf_sel = s2_q.sign;
            RUP:     inf_sel = !s2_q.sign;
            default: inf_sel = 1'b1;
        endcase

        out_d     = '0;
        out_d.tag = s2_q.tag;
        out_d.z   = {s2_q.sign, e_fin[EXP_W-1:0], rnd_mant[FRAC_W-1:0]};
        if (s2_q.nan) begin
            out_d.z  = QNAN;
            out_d.nv = 1'b1;
        end else if (s2_q.inf) begin
            out_d.z = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (s2_q.zero) begin
            out_d.z = {s2_q.sign, {(W-1){1'b0}}};
        end else if (ofl) begin
            out_d.ovrf = 1'b1;
            out_d.z    = inf_sel ? {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                                 : {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        end else if (ufl) begin
            out_d.udrf = 1'b1;
            out_d.z    = {s2_q.sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_q      <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_q      <= out_d;
        end
    end

`ifdef FP_MUL_ASSERT_EN
    logic [STAGES:1] sgn_pipe_q;

    always_ff @(posedge clk) begin
        if (rst)      sgn_pipe_q <= '0;
        else if (adv) sgn_pipe_q <= {sgn_pipe_q[STAGES-1:1], fp_x[W-1] ^ fp_y[W-1]};
    end

    always_comb begin
        if (!rst && vld_pipe_q[2] && rnd_carry) a_carry_ones: assert (&s2_q.mant);
    end

    a_in_ready: assert property (@(posedge clk) in_ready == (!out_valid || out_ready));
    a_norm_msb: assert property (@(posedge clk) disable iff (rst)
        vld_pipe_q[2] && !(s2_q.nan || s2_q.inf || s2_q.zero) |-> s2_q.mant[FRAC_W]);
    a_sticky: assert property (@(posedge clk) disable iff (rst)
        adv && vld_pipe_q[1] |=> s2_q.s == $past(|norm[FRAC_W-2:0]));
    a_sign: assert property (@(posedge clk) disable iff (rst)
        out_valid && !nv |-> fp_z[W-1] == sgn_pipe_q[STAGES]);
    a_stable: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable({fp_z, out_tag, ovrf, udrf, nv}));
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (FP32): vector table, backpressure and reset-mid-burst sequences.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovrf, udrf, nv;
    logic [31:0] fp_x, fp_y, fp_z;
    logic [2:0]  r_mode;
    logic [3:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fp_x(fp_x), .fp_y(fp_y), .r_mode(r_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .fp_z(fp_z),
        .out_tag(out_tag), .ovrf(ovrf), .udrf(udrf), .nv(nv)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] z;
        logic [2:0]  fl;   // {ovrf, udrf, nv}
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic [2:0]  fl;
        int          acc;
        bit          lat;
    } sb_t;

    localparam int NV = 23;
    vec_t vt[NV];
    sb_t  sbq[$];
    sb_t  cur_exp, mon_e;
    int   cyc = 0, checks = 0, passes = 0, acc_cnt = 0, pop_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    pop_cnt++;
                    chk($sformatf("z_tag%0d", mon_e.tag), fp_z, mon_e.z);
                    chk("tag", 32'(out_tag), 32'(mon_e.tag));
                    chk($sformatf("flags_tag%0d", mon_e.tag), 32'({ovrf, udrf, nv}), 32'(mon_e.fl));
                    if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                mon_e     = cur_exp;
                mon_e.acc = cyc;
                sbq.push_back(mon_e);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        input logic [3:0] tag, input logic [31:0] z, input logic [2:0] fl,
                        input bit lat);
        int n;
        @(negedge clk);
        fp_x     = x;
        fp_y     = y;
        r_mode   = rm;
        in_tag   = tag;
        in_valid = 1'b1;
        cur_exp  = '{z: z, tag: tag, fl: fl, acc: 0, lat: lat};
        #3;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fp_x = '0; fp_y = '0; r_mode = '0; in_tag = '0;
        cur_exp = '{z: 0, tag: 0, fl: 0, acc: 0, lat: 0};

        vt[0]  = '{32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 3'b000};
        vt[1]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 3'b000};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 3'b000};
        vt[3]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 3'b000};
        vt[4]  = '{32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 3'b000};
        vt[5]  = '{32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 3'b000};
        vt[6]  = '{32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 3'b100};
        vt[7]  = '{32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 3'b100};
        vt[8]  = '{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 3'b010};
        vt[9]  = '{32'h80000001, 32'h3F800000, 3'd0, 32'h80000000, 3'b000};
        vt[10] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b001};
        vt[11] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 3'b000};
        vt[12] = '{32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 3'b000};
        vt[13] = '{32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 3'b000};
        vt[14] = '{32'h7F7FFFFE, 32'h3F800001, 3'd0, 32'h7F800000, 3'b100};
        vt[15] = '{32'hFF000000, 32'h7F000000, 3'd2, 32'hFF800000, 3'b100};
        vt[16] = '{32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, 3'b100};
        vt[17] = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 3'b010};
        vt[18] = '{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 3'b000};
        vt[19] = '{32'h7FC00001, 32'h3F800000, 3'd4, 32'h7FC00000, 3'b001};
        vt[20] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 3'b000};
        vt[21] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 3'b000};
        vt[22] = '{32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800002, 3'b000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fp_z", fp_z, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'({ovrf, udrf, nv}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            send(vt[i].x, vt[i].y, vt[i].rm, 4'(i), vt[i].z, vt[i].fl, i == 0);
        idle();
        drain();

        // Backpressure: six back-to-back ops against a stalled consumer.
        base = acc_cnt;
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h3F800000, 32'h40000000 + (32'(i) << 16), 3'd0, 4'(8 + i),
                         32'h40000000 + (32'(i) << 16), 3'b000, 1'b0);
                idle();
            end
            begin
                repeat (5) @(negedge clk);
                #3;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_accepted", 32'(acc_cnt - base), 32'd3);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_z_a", fp_z, 32'h40000000);
                repeat (2) @(negedge clk);
                #3;
                chk("stall_z_b", fp_z, 32'h40000000);
                chk("stall_tag_b", 32'(out_tag), 32'd8);
                chk("stall_valid_b", 32'(out_valid), 32'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        base = pop_cnt;
        drain();
        chk("bp_accepted_total", 32'(acc_cnt), 32'(NV + 6));
        chk("bp_popped_total", 32'(pop_cnt), 32'(NV + 6));

        // Reset in the middle of a burst discards everything in flight.
        for (int i = 0; i < 3; i++)
            send(vt[i].x, vt[i].y, vt[i].rm, 4'(12 + i), vt[i].z, vt[i].fl, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            chk($sformatf("midrst_idle%0d", i), 32'(out_valid), 32'd0);
        end
        send(vt[5].x, vt[5].y, vt[5].rm, 4'd15, vt[5].z, vt[5].fl, 1'b1);
        idle();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
